// File: rtl/worker_pipe.sv
// worker_pipe: pipelined dataflow worker. Holds one packet from the capture
// stage and issues 1-3 worker-results toward the result router, one per cycle.
// Optional feature macro: WORKER_ARITH_EXT_EN enables MINUS/LT/EQ (opcodes 6-8);
// without it those opcodes are dropped as illegal and their logic is not built.
module worker_pipe #(
  parameter int OPC_W   = 4,
  parameter int OPT_W   = 2,
  parameter int ADDR_W  = 10,
  parameter int COLOR_W = 16,
  parameter int DATA_W  = 32
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic                                          RECEIVE_PC_VALID,
  input  logic [OPC_W+OPT_W+ADDR_W+COLOR_W+4*DATA_W-1:0] RECEIVE_PC_DATA,
  output logic                                          RECEIVE_PC_READY,
  output logic                                          SEND_WR_VALID,
  output logic [OPT_W+ADDR_W+COLOR_W+DATA_W-1:0]        SEND_WR_DATA,
  input  logic                                          SEND_WR_READY,
  output logic                                          ERR_ILLEGAL
);

  localparam int PACKET_WIDTH        = OPC_W + OPT_W + ADDR_W + COLOR_W + 4 * DATA_W;
  localparam int WORKER_RESULT_WIDTH = OPT_W + ADDR_W + COLOR_W + DATA_W;
  localparam int DST_W               = OPT_W + ADDR_W;

  // Field positions inside the packet, LSB first
  localparam int D4_LSB   = 0;
  localparam int D3_LSB   = DATA_W;
  localparam int D2_LSB   = 2 * DATA_W;
  localparam int D1_LSB   = 3 * DATA_W;
  localparam int COL_LSB  = 4 * DATA_W;
  localparam int ADDR_LSB = COL_LSB + COLOR_W;
  localparam int OPT_LSB  = ADDR_LSB + ADDR_W;
  localparam int OPC_LSB  = OPT_LSB + OPT_W;

  localparam logic [OPC_W-1:0] OPC_NOP   = OPC_W'(4'd0);
  localparam logic [OPC_W-1:0] OPC_DIST  = OPC_W'(4'd1);
  localparam logic [OPC_W-1:0] OPC_SWTCH = OPC_W'(4'd2);
  localparam logic [OPC_W-1:0] OPC_SETC  = OPC_W'(4'd3);
  localparam logic [OPC_W-1:0] OPC_SYNC  = OPC_W'(4'd4);
  localparam logic [OPC_W-1:0] OPC_PLUS  = OPC_W'(4'd5);
`ifdef WORKER_ARITH_EXT_EN
  localparam logic [OPC_W-1:0] OPC_MINUS = OPC_W'(4'd6);
  localparam logic [OPC_W-1:0] OPC_LT    = OPC_W'(4'd7);
  localparam logic [OPC_W-1:0] OPC_EQ    = OPC_W'(4'd8);
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [1:0]                       r_idx;
  logic [1:0]                       w_idx_nxt;
  logic [PACKET_WIDTH-1:0]          r_pkt;
  logic                             r_out_valid;
  logic [WORKER_RESULT_WIDTH-1:0]   r_out_data;

  // Held-packet fields; results are built only from these, never the live bus
  logic [OPC_W-1:0]   w_opc;
  logic [DST_W-1:0]   w_pkt_dst;
  logic [COLOR_W-1:0] w_color;
  logic [DATA_W-1:0]  w_d1;
  logic [DATA_W-1:0]  w_d2;
  logic [DST_W-1:0]   w_d3_dst;
  logic [DATA_W-1:0]  w_d4;

  assign w_opc     = r_pkt[OPC_LSB +: OPC_W];
  assign w_pkt_dst = r_pkt[ADDR_LSB +: DST_W];
  assign w_color   = r_pkt[COL_LSB +: COLOR_W];
  assign w_d1      = r_pkt[D1_LSB +: DATA_W];
  assign w_d2      = r_pkt[D2_LSB +: DATA_W];
  assign w_d3_dst  = r_pkt[D3_LSB +: DST_W];
  assign w_d4      = r_pkt[D4_LSB +: DATA_W];

  // A destination word carries {option, addr} in its low bits, matching the result layout
  function automatic logic [WORKER_RESULT_WIDTH-1:0] mk_res(
    input logic [DST_W-1:0]   dst,
    input logic [COLOR_W-1:0] col,
    input logic [DATA_W-1:0]  val
  );
    return {dst, col, val};
  endfunction

  logic [WORKER_RESULT_WIDTH-1:0] w_res0;
  logic [WORKER_RESULT_WIDTH-1:0] w_res1;
  logic [WORKER_RESULT_WIDTH-1:0] w_res2;
  logic [WORKER_RESULT_WIDTH-1:0] w_sel;
  logic [1:0]                     w_num;
  logic                           w_nop;
  logic                           w_illegal;

  // Opcode decode: result list and result count for the held packet
  always_comb begin
    w_res0    = '0;
    w_res1    = '0;
    w_res2    = '0;
    w_num     = 2'd1;
    w_nop     = 1'b0;
    w_illegal = 1'b0;
    case (w_opc)
      OPC_NOP: begin
        w_nop = 1'b1;
      end
      OPC_DIST: begin
        w_res0 = mk_res(w_d2[DST_W-1:0], w_color, w_d1);
        w_res1 = mk_res(w_d3_dst, w_color, w_d1);
        w_res2 = mk_res(w_d4[DST_W-1:0], w_color, w_d1);
        // an all-ones third destination is a sentinel and is skipped
        if (w_d4 == {DATA_W{1'b1}}) begin
          w_num = 2'd2;
        end else begin
          w_num = 2'd3;
        end
      end
      OPC_SWTCH: begin
        if (w_d2 != {DATA_W{1'b0}}) begin
          w_res0 = mk_res(w_d3_dst, w_color, w_d1);
        end else begin
          w_res0 = mk_res(w_d4[DST_W-1:0], w_color, w_d1);
        end
      end
      OPC_SETC: begin
        w_res0 = mk_res(w_pkt_dst, w_d2[COLOR_W-1:0], w_d1);
      end
      OPC_SYNC: begin
        w_res0 = mk_res(w_d3_dst, w_color, w_d1);
        w_res1 = mk_res(w_d4[DST_W-1:0], w_color, w_d2);
        w_num  = 2'd2;
      end
      OPC_PLUS: begin
        w_res0 = mk_res(w_pkt_dst, w_color, w_d1 + w_d2);
      end
`ifdef WORKER_ARITH_EXT_EN
      OPC_MINUS: begin
        w_res0 = mk_res(w_pkt_dst, w_color, w_d1 - w_d2);
      end
      OPC_LT: begin
        w_res0 = mk_res(w_pkt_dst, w_color, {{(DATA_W-1){1'b0}}, (w_d1 < w_d2)});
      end
      OPC_EQ: begin
        w_res0 = mk_res(w_pkt_dst, w_color, {{(DATA_W-1){1'b0}}, (w_d1 == w_d2)});
      end
`endif
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Select the result addressed by the emit index
  always_comb begin
    w_sel = '0;
    case (r_idx)
      2'd0:    w_sel = w_res0;
      2'd1:    w_sel = w_res1;
      2'd2:    w_sel = w_res2;
      default: w_sel = '0;
    endcase
  end

  logic w_out_free;
  logic w_load;
  logic w_retire;
  logic w_ready;
  logic w_accept;

  assign w_out_free = !r_out_valid || SEND_WR_READY;

  // Issue control: load one result per free output slot, retire on the last one
  always_comb begin
    w_load   = 1'b0;
    w_retire = 1'b0;
    if (r_state == S_EMIT) begin
      if (w_nop || w_illegal) begin
        w_retire = 1'b1;
      end else if (w_out_free) begin
        w_load = 1'b1;
        if (r_idx == (w_num - 2'd1)) begin
          w_retire = 1'b1;
        end else begin
          w_retire = 1'b0;
        end
      end else begin
        w_load   = 1'b0;
        w_retire = 1'b0;
      end
    end else begin
      w_load   = 1'b0;
      w_retire = 1'b0;
    end
  end

  // Ready is forced low while reset is asserted so every output reads 0 in reset
  assign w_ready  = RST && ((r_state == S_IDLE) || w_retire);
  assign w_accept = RECEIVE_PC_VALID && w_ready;

  // Next state: a new packet overrides retirement so back-to-back packets never bubble
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_accept) begin
      w_state_nxt = S_EMIT;
      w_idx_nxt   = 2'd0;
    end else if (w_retire) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 2'd0;
    end else if (w_load) begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx + 2'd1;
    end else begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
    end
  end

  // State and emit-index registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Packet holding register, loaded only on an accepted transfer
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pkt <= '0;
    end else if (w_accept) begin
      r_pkt <= RECEIVE_PC_DATA;
    end else begin
      r_pkt <= r_pkt;
    end
  end

  // Registered result output; data holds until the router takes it
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel;
    end else if (SEND_WR_READY) begin
      r_out_valid <= 1'b0;
      r_out_data  <= r_out_data;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
    end
  end

  assign RECEIVE_PC_READY = w_ready;
  assign SEND_WR_VALID    = r_out_valid;
  assign SEND_WR_DATA     = r_out_data;
  assign ERR_ILLEGAL      = (r_state == S_EMIT) && w_illegal;

endmodule

// File: doc/worker_pipe.md
Name: worker_pipe

Overview:
- Parametrised, pipelined successor of the single-issue dataflow worker.
- Consumes one packet from the packet-capture stage and emits 1-3 worker-results toward the result router.
- Operand, colour and address widths are parametrised.
- Sustains one result per cycle: the next packet is accepted while the current one issues its last result.
- Adds an N-way distribute, sentinel-skipped destinations, and illegal-opcode reporting.

Parameters:
- OPC_W, 4, opcode field width.
- OPT_W, 2, destination option width.
- ADDR_W, 10, destination address width.
- COLOR_W, 16, colour width.
- DATA_W, 32, operand width; must be >= OPT_W+ADDR_W.
- Derived localparam PACKET_WIDTH = OPC_W+OPT_W+ADDR_W+COLOR_W+4*DATA_W.
- Derived localparam WORKER_RESULT_WIDTH = OPT_W+ADDR_W+COLOR_W+DATA_W.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset; asynchronous assert, active-low (0 = reset); release is synchronised upstream.
- RECEIVE_PC_VALID  in  1  packet valid.
- RECEIVE_PC_DATA  in  PACKET_WIDTH  packet. Fields MSB to LSB: opcode, dest_option, dest_addr, color, data1, data2, data3, data4.
- RECEIVE_PC_READY  out  1  packet ready.
- SEND_WR_VALID  out  1  result valid.
- SEND_WR_DATA  out  WORKER_RESULT_WIDTH  result. Fields MSB to LSB: option, addr, color, value.
- SEND_WR_READY  in  1  result ready.
- ERR_ILLEGAL  out  1  one-cycle pulse when an illegal opcode is dropped.

Behaviour:
- Reset values: all outputs 0; holding register empty; emit index 0.
- Assertion mid-transfer discards the held packet and any pending result immediately.
- Handshake: a transfer occurs on any edge where VALID && READY.
  - SEND_WR_VALID/SEND_WR_DATA are registered.
  - Once VALID is high, DATA is stable until the accepting edge.
  - The output register may load when out_free = !SEND_WR_VALID || SEND_WR_READY.
- RECEIVE_PC_READY is combinational: !held || (last result of held packet loads this cycle).
  - It never depends on RECEIVE_PC_VALID.
- States:
  - S_IDLE (nothing held): an accepted packet goes to S_EMIT with idx = 0.
  - S_EMIT: on each out_free cycle, load result[idx] and increment idx.
    - On the last result, return to S_IDLE, or stay in S_EMIT with idx = 0 if a new packet is accepted on the same edge.
  - NOP and illegal opcodes retire on the first S_EMIT cycle without loading a result.
  - An illegal opcode pulses ERR_ILLEGAL in that same cycle.
- Latency: packet accepted at edge N gives SEND_WR_VALID high after edge N+1.
- Throughput: 1 result per cycle with SEND_WR_READY held high.
- Direct destination word w: option = w[OPT_W+ADDR_W-1:ADDR_W], addr = w[ADDR_W-1:0]; upper bits ignored.
- Opcodes:
  - 0 NOP: no result.
  - 1 DISTRIBUTE: value data1, packet color, destinations data2, data3, data4 in order. data4 == all-ones (sentinel) is skipped, giving 2 results instead of 3.
  - 2 SWITCH: destination data3 if data2 != 0, else data4; value data1; packet color.
  - 3 SET_COLOR: packet dest fields; color data2[COLOR_W-1:0]; value data1.
  - 4 SYNC: first (data3, color, data1), then (data4, color, data2).
  - 5 PLUS: packet dest fields and color; value (data1+data2) mod 2^DATA_W; carry discarded.
  - 6 MINUS: value (data1-data2) mod 2^DATA_W.
  - 7 LT: value 1 if data1 < data2 (unsigned), else 0.
  - 8 EQ: value 1 if data1 == data2, else 0.
  - 9..2^OPC_W-1: illegal.
- Result values are computed from the held register only, never from the live input bus.
- Back-pressure: with SEND_WR_READY low, idx, the held packet and SEND_WR_DATA hold indefinitely, and RECEIVE_PC_READY stays low while holding.

Optional Feature:
- Macro WORKER_ARITH_EXT_EN.
- Defined: opcodes 6-8 (MINUS, LT, EQ) are legal as above.
- Undefined: opcodes 6-8 are illegal — dropped with ERR_ILLEGAL pulse and no result; subtractor and comparators are not synthesised.

Test Plan:
- DISTRIBUTE with data1=0x55, color=0x0007, data2={opt1,addr3}, data3={opt2,addr9}, data4=all-ones, READY=1 -> exactly two results, (1,3,7,0x55) then (2,9,7,0x55), on consecutive cycles; third result suppressed.
- Back-to-back PLUS 0xFFFFFFFF+2, then SYNC, both VALID continuously, READY=1 -> results 0x00000001, SYNC#1, SYNC#2 on three consecutive cycles; second packet accepted on the same edge the PLUS result loads.
- SEND_WR_READY low for 5 cycles mid-DISTRIBUTE -> SEND_WR_DATA stable, RECEIVE_PC_READY=0; resumes with the second result after READY rises; no duplicates or drops.
- SWITCH data2=0 vs data2=1 -> routes to data4 vs data3 respectively; SET_COLOR data2=0x1234ABCD -> result color 0xABCD.
- Opcode 0xF -> no result, ERR_ILLEGAL high exactly 1 cycle, next packet accepted; repeat with opcode 7 and the macro undefined -> same; with the macro defined, LT 3<5 -> value 1.
- RST driven low asynchronously (between edges) while VALID=1 with a result pending -> VALID, RECEIVE_PC_READY and ERR_ILLEGAL go 0 without a clock edge; after release, the first packet behaves as from reset.
